// File: rtl/shared_dp_arbiter_if.sv
// Request fabric / datapath / response bundle for shared_dp_arbiter.
// master = fabric + datapath side, slave = the arbiter.
interface shared_dp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DIN_W   = 6,
  parameter int DOUT_W  = 10,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DIN_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [DIN_W-1:0]         dp_in;
  logic [DOUT_W-1:0]        dp_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DOUT_W-1:0]        rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;
  logic [15:0]              ops_done;

  modport master (
    output req_valid, req_data, dp_out, rsp_ready,
    input  req_ready, dp_in, rsp_valid, rsp_data, rsp_id, busy, ops_done
  );
  modport slave (
    input  req_valid, req_data, dp_out, rsp_ready,
    output req_ready, dp_in, rsp_valid, rsp_data, rsp_id, busy, ops_done
  );
endinterface

// File: rtl/shared_dp_arbiter.sv
// Round-robin arbiter that time-shares one combinational datapath among
// NUM_REQ requesters: grant, hold operand DP_LAT cycles, return result + id.
module shared_dp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DIN_W   = 6,
  parameter int DOUT_W  = 10,
  parameter int DP_LAT  = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  shared_dp_arbiter_if.slave  bus
);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [DIN_W-1:0]    op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DOUT_W-1:0]   rdata_q, rdata_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [15:0]         ops_q, ops_d;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic                can_grant;
  logic                grant;

  // Search starts one past the last winner so every holder is reached
  // within NUM_REQ grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    can_grant = !rst && ((state_q == IDLE) || (state_q == RESP && bus.rsp_ready));
    grant     = can_grant && gnt_found;
    bus.req_ready = '0;
    if (grant) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: ;
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = bus.dp_out;
          rid_d   = id_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant in RESP overrides the IDLE return for back-to-back ops.
    if (grant) begin
      op_d    = bus.req_data[int'(gnt_idx)*DIN_W +: DIN_W];
      id_d    = gnt_idx;
      ptr_d   = gnt_idx;
      cnt_d   = CNT_W'(DP_LAT);
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      id_q    <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      rdata_q <= '0;
      rid_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      ops_q   <= ops_d;
    end
  end

  logic [15:0] ops_done_q;
  assign ops_done_q = ops_q;

  assign bus.dp_in     = op_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_id    = rid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.ops_done  = ops_done_q;
endmodule
